imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, sets the instruction-memory word-address width (DEPTH = 2^ADDR_W words).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 in_valid  input  1  byte-stream data valid.
REQ-005 in_data  input  8  byte-stream payload.
REQ-006 in_ready  output  1  loader accepts a byte; a byte transfers when in_valid and in_ready are both 1 at a rising edge.
REQ-007 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-008 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-009 mem_wdata  output  32  instruction word to write.
REQ-010 cpu_rst  output  1  reset to the mips_pipeline core; 1 holds the core in reset.
REQ-011 done  output  1  load finished and checksum matched.
REQ-012 err  output  1  load aborted.

Function
REQ-013 Frame format: count high byte, count low byte (N, 16-bit, big-endian), then 4*N word bytes (each word MSB first), then one checksum byte.
REQ-014 Checksum: XOR of every byte before it, header included; checksum byte must equal that XOR.
REQ-015 States: CNT_HI, CNT_LO, DATA, CHK, RUN, ERR.
REQ-016 CNT_HI -> CNT_LO on the first byte accepted; CNT_LO -> DATA on the second byte when N is between 1 and DEPTH; -> CHK when N = 0; -> ERR when N > DEPTH.
REQ-017 DATA: bytes shift into a 32-bit packer; on the 4th byte of a word, the next cycle has mem_we = 1, mem_wdata = the packed word, and mem_addr = the word index (0-based).
REQ-018 mem_we is 0 in every other cycle; mem_addr and mem_wdata are don't-care when mem_we = 0.
REQ-019 DATA -> CHK on the 4th byte of word N-1.
REQ-020 CHK -> RUN on a matching checksum byte; CHK -> ERR on a mismatch.
REQ-021 in_ready = 1 in CNT_HI, CNT_LO, DATA and CHK; in_ready = 0 in RUN and ERR.
REQ-022 Back-to-back bytes are accepted at one per cycle. A word write pulse overlapping acceptance of the next word's first byte is legal.
REQ-023 in_valid = 0 stalls the FSM with no state change and no timeout.
REQ-024 RUN: cpu_rst = 0 and done = 1 from the cycle after the checksum byte is accepted; both hold until rst.
REQ-025 ERR: cpu_rst = 1, err = 1, done = 0; held until rst.
REQ-026 The word index counter is ADDR_W+1 bits wide and never wraps. N = DEPTH writes exactly addresses 0..DEPTH-1.

Reset
REQ-027 rst = 1 forces state CNT_HI, clears packer, checksum, byte and word counters, and drives in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, err=0 immediately, without waiting for a clock.
REQ-028 rst asserted mid-frame or in RUN discards the partial frame; the next frame starts at CNT_HI after deassertion.
REQ-029 cpu_rst is never 0 while rst = 1.

Structure
REQ-030 The state enumeration and the frame constants (header length 2, bytes per word 4) live in the shared package mips_pkg.
REQ-031 The 4-byte shift/pack logic and its byte counter form one sub-module, word_packer; the FSM, checksum and word counter stay in imem_loader.

Verification
REQ-032 Frame 00 02 | 24 08 00 05 | 00 00 00 00 | checksum 2B sent back-to-back produces:
  - writes (0, 0x24080005) and (1, 0x00000000);
  - done = 1 and cpu_rst = 0 one cycle after the checksum byte.
REQ-033 The same frame with checksum 2A -> both words written, then err = 1, cpu_rst stays 1, and in_ready = 0.
REQ-034 Frame 00 00 00 -> no mem_we pulse, and done = 1.
REQ-035 ADDR_W = 8 with header 01 01 -> ERR after the second byte, and no write occurs.
REQ-036 The frame of REQ-032 with in_valid deasserted for 3 cycles between every byte -> identical writes and the same final done = 1.
REQ-037 rst pulsed after 5 data bytes, then the full frame of REQ-032 resent -> outputs at reset values during rst, then the correct writes and done = 1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and the byte-stream frame layout constants.
package mips_pkg;

  typedef enum logic [2:0] {
    CNT_HI,
    CNT_LO,
    DATA,
    CHK,
    RUN,
    ERR
  } loader_state_e;

  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_packer.sv
// Shifts incoming bytes MSB-first into a 32-bit word and flags the byte
// that completes each word; word_out is valid in that same cycle.
module word_packer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_done
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [23:0]      shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign word_out  = {shift_q, byte_in};
  assign word_done = byte_valid && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (byte_valid) begin
      shift_d = {shift_q[15:0], byte_in};
      cnt_d   = word_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a framed byte stream (count, words, XOR checksum), writes the words
// into instruction memory and releases the core from reset on a valid frame.
module imem_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [7:0]        chk_q, chk_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              accept;
  logic              pack_valid;
  logic [31:0]       packed_word;
  logic              word_done;
  logic [15:0]       n_full;
  logic              last_word;

  assign accept     = in_valid && in_ready;
  assign pack_valid = accept && (state_q == DATA);
  assign n_full     = {n_q[15:8], in_data};
  assign last_word  = ({{(31 - ADDR_W){1'b0}}, word_cnt_q} + 32'd1) == {16'h0000, n_q};

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (pack_valid),
    .byte_in    (in_data),
    .word_out   (packed_word),
    .word_done  (word_done)
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    chk_d      = chk_q;
    word_cnt_d = word_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      CNT_HI: begin
        if (accept) begin
          n_d     = {in_data, 8'h00};
          chk_d   = chk_q ^ in_data;
          state_d = CNT_LO;
        end
      end
      CNT_LO: begin
        if (accept) begin
          n_d   = n_full;
          chk_d = chk_q ^ in_data;
          if (n_full == 16'h0000)
            state_d = CHK;
          else if ({16'h0000, n_full} > DEPTH)
            state_d = ERR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          chk_d = chk_q ^ in_data;
          if (word_done) begin
            we_d       = 1'b1;
            addr_d     = word_cnt_q[ADDR_W-1:0];
            wdata_d    = packed_word;
            word_cnt_d = word_cnt_q + (ADDR_W + 1)'(1);
            if (last_word)
              state_d = CHK;
          end
        end
      end
      CHK: begin
        if (accept)
          state_d = (in_data == chk_q) ? RUN : ERR;
      end
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  // All outputs derive from reset-cleared flops, so rst takes effect without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CNT_HI;
      n_q        <= '0;
      chk_q      <= '0;
      word_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      chk_q      <= chk_d;
      word_cnt_q <= word_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign in_ready  = (state_q == CNT_HI) || (state_q == CNT_LO) ||
                     (state_q == DATA)   || (state_q == CHK);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst   = (state_q != RUN);
  assign done      = (state_q == RUN);
  assign err       = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: good/bad frames, empty and
// oversize counts, full-depth load, stalled stream and mid-frame reset.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              err;

  int n_compared = 0;
  int n_mismatch = 0;

  logic [7:0]        tx[$];
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_tx(input int gap);
    foreach (tx[i]) begin
      in_valid = 1'b1;
      in_data  = tx[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic load_ref_frame(input logic [7:0] chk);
    tx = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00};
    tx.push_back(chk);
  endtask

  task automatic check_ref_writes(input string tag);
    n_compared++;
    if (wr_addr.size() !== 2) begin
      n_mismatch++;
      $display("[TB] FAIL %s write count: got %0d expected 2", tag, wr_addr.size());
    end else begin
      n_compared++;
      if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h24080005) begin
        n_mismatch++;
        $display("[TB] FAIL %s word0: got (%0d,%h) expected (0,24080005)", tag, wr_addr[0], wr_data[0]);
      end
      n_compared++;
      if (wr_addr[1] !== 8'd1 || wr_data[1] !== 32'h00000000) begin
        n_mismatch++;
        $display("[TB] FAIL %s word1: got (%0d,%h) expected (1,00000000)", tag, wr_addr[1], wr_data[1]);
      end
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    n_compared++; if (in_ready !== 1'b1)  begin n_mismatch++; $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready); end
    n_compared++; if (mem_we !== 1'b0)    begin n_mismatch++; $display("[TB] FAIL reset mem_we: got %b expected 0", mem_we); end
    n_compared++; if (mem_addr !== 8'h00) begin n_mismatch++; $display("[TB] FAIL reset mem_addr: got %h expected 00", mem_addr); end
    n_compared++; if (mem_wdata !== 32'h0) begin n_mismatch++; $display("[TB] FAIL reset mem_wdata: got %h expected 0", mem_wdata); end
    n_compared++; if (cpu_rst !== 1'b1)   begin n_mismatch++; $display("[TB] FAIL reset cpu_rst: got %b expected 1", cpu_rst); end
    n_compared++; if (done !== 1'b0)      begin n_mismatch++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    n_compared++; if (err !== 1'b0)       begin n_mismatch++; $display("[TB] FAIL reset err: got %b expected 0", err); end
  endtask

  task automatic test_good_frame();
    do_reset();
    load_ref_frame(8'h2B);
    void'(tx.pop_back());
    send_tx(0);
    n_compared++; if (done !== 1'b0) begin n_mismatch++; $display("[TB] FAIL good pre-chk done: got %b expected 0", done); end
    n_compared++; if (mem_we !== 1'b1 || mem_addr !== 8'd1) begin n_mismatch++; $display("[TB] FAIL good word1 pulse: got we=%b addr=%0d expected we=1 addr=1", mem_we, mem_addr); end
    tx = '{8'h2B};
    send_tx(0);
    n_compared++; if (done !== 1'b1)    begin n_mismatch++; $display("[TB] FAIL good done: got %b expected 1", done); end
    n_compared++; if (cpu_rst !== 1'b0) begin n_mismatch++; $display("[TB] FAIL good cpu_rst: got %b expected 0", cpu_rst); end
    n_compared++; if (in_ready !== 1'b0 || err !== 1'b0) begin n_mismatch++; $display("[TB] FAIL good ready/err: got %b/%b expected 0/0", in_ready, err); end
    check_ref_writes("good");
    repeat (3) @(posedge clk);
    #1;
    n_compared++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin n_mismatch++; $display("[TB] FAIL good hold: got done=%b cpu_rst=%b expected 1/0", done, cpu_rst); end
  endtask

  task automatic test_bad_checksum();
    do_reset();
    load_ref_frame(8'h2A);
    send_tx(0);
    @(posedge clk);
    #1;
    check_ref_writes("badchk");
    n_compared++; if (err !== 1'b1)      begin n_mismatch++; $display("[TB] FAIL badchk err: got %b expected 1", err); end
    n_compared++; if (cpu_rst !== 1'b1)  begin n_mismatch++; $display("[TB] FAIL badchk cpu_rst: got %b expected 1", cpu_rst); end
    n_compared++; if (in_ready !== 1'b0) begin n_mismatch++; $display("[TB] FAIL badchk in_ready: got %b expected 0", in_ready); end
    n_compared++; if (done !== 1'b0)     begin n_mismatch++; $display("[TB] FAIL badchk done: got %b expected 0", done); end
  endtask

  task automatic test_empty_frame();
    do_reset();
    tx = '{8'h00, 8'h00, 8'h00};
    send_tx(0);
    repeat (2) @(posedge clk);
    #1;
    n_compared++; if (wr_addr.size() !== 0) begin n_mismatch++; $display("[TB] FAIL empty writes: got %0d expected 0", wr_addr.size()); end
    n_compared++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin n_mismatch++; $display("[TB] FAIL empty done: got done=%b cpu_rst=%b expected 1/0", done, cpu_rst); end
  endtask

  task automatic test_oversize();
    do_reset();
    tx = '{8'h01, 8'h01};
    send_tx(0);
    n_compared++; if (err !== 1'b1 || in_ready !== 1'b0) begin n_mismatch++; $display("[TB] FAIL oversize err/ready: got %b/%b expected 1/0", err, in_ready); end
    tx = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_tx(0);
    @(posedge clk);
    #1;
    n_compared++; if (wr_addr.size() !== 0) begin n_mismatch++; $display("[TB] FAIL oversize writes: got %0d expected 0", wr_addr.size()); end
    n_compared++; if (cpu_rst !== 1'b1 || done !== 1'b0) begin n_mismatch++; $display("[TB] FAIL oversize cpu_rst/done: got %b/%b expected 1/0", cpu_rst, done); end
  endtask

  task automatic test_full_depth();
    logic [7:0]  x;
    logic [31:0] w;
    int          bad;
    do_reset();
    tx = '{8'h01, 8'h00};
    x  = 8'h01;
    for (int i = 0; i < 256; i++) begin
      w = {8'hA5, 8'(i), ~8'(i), 8'h3C};
      for (int b = 3; b >= 0; b--) begin
        tx.push_back(w[b*8 +: 8]);
        x = x ^ w[b*8 +: 8];
      end
    end
    tx.push_back(x);
    send_tx(0);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] !== 8'(i) || wr_data[i] !== {8'hA5, 8'(i), ~8'(i), 8'h3C}) bad++;
    n_compared++; if (wr_addr.size() !== 256) begin n_mismatch++; $display("[TB] FAIL depth write count: got %0d expected 256", wr_addr.size()); end
    n_compared++; if (bad !== 0) begin n_mismatch++; $display("[TB] FAIL depth write contents: got %0d wrong expected 0", bad); end
    n_compared++; if (done !== 1'b1 || err !== 1'b0) begin n_mismatch++; $display("[TB] FAIL depth done/err: got %b/%b expected 1/0", done, err); end
  endtask

  task automatic test_stall();
    do_reset();
    load_ref_frame(8'h2B);
    send_tx(3);
    check_ref_writes("stall");
    n_compared++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin n_mismatch++; $display("[TB] FAIL stall done: got done=%b cpu_rst=%b expected 1/0", done, cpu_rst); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    tx = '{8'h00, 8'h02, 8'h24, 8'h08, 8'h00, 8'h05, 8'h00};
    send_tx(0);
    rst = 1'b1;
    #2;
    n_compared++; if (mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin n_mismatch++; $display("[TB] FAIL midrst mem: got we=%b addr=%h data=%h expected 0/00/0", mem_we, mem_addr, mem_wdata); end
    n_compared++; if (in_ready !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin n_mismatch++; $display("[TB] FAIL midrst ctl: got ready=%b cpu_rst=%b done=%b err=%b expected 1/1/0/0", in_ready, cpu_rst, done, err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    wr_addr.delete();
    wr_data.delete();
    load_ref_frame(8'h2B);
    send_tx(0);
    check_ref_writes("midrst");
    n_compared++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin n_mismatch++; $display("[TB] FAIL midrst done: got done=%b cpu_rst=%b expected 1/0", done, cpu_rst); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_empty_frame();
    test_oversize();
    test_full_depth();
    test_stall();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
